// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED pattern controller.
//   mode_e : 2-bit runtime mode encoding as presented on the `mode` pins
//            (MODE_BINARY / MODE_CHASE / MODE_BREATHE / MODE_STATIC).
//   dir_e  : travel direction shared by the chase position and the
//            breathe duty ramp.
// ---------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        MODE_BINARY  = 2'd0,
        MODE_CHASE   = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_STATIC  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage : led_pkg

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Free-running prescaler that produces one step strobe every 2^WIDTH
// enabled clocks.
//   clk    : board clock, rising edge
//   rst    : asynchronous active-high reset
//   en     : count enable; low freezes the prescaler
//   strobe : combinational, high for the enabled clock on which the
//            prescaler is all-ones (the clock that wraps it to zero)
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int unsigned WIDTH = 21
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic strobe
);

    logic [WIDTH-1:0] presc_q;
    logic [WIDTH-1:0] presc_d;

    always_comb begin
        presc_d = presc_q;
        if (en) begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Strobe on the clock that takes the prescaler from all-ones back to
    // zero, so the first strobe is the 2^WIDTH-th enabled clock.
    assign strobe = en && (presc_q == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule : tick_gen

// File: rtl/led_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// led_pattern_ctrl
// N-channel LED pattern controller with four runtime modes:
// binary-rate blink, bounce chase, PWM breathe and static pattern.
//   clk     : board clock, all logic on rising edge
//   rst     : asynchronous active-high reset
//   en      : count enable; low freezes prescaler and all pattern state
//   mode    : requested mode (0 BINARY, 1 CHASE, 2 BREATHE, 3 STATIC),
//             adopted only on a step strobe
//   pattern : LED pattern shown in STATIC mode, sampled every clock
//   led     : registered LED drive, 1 = on
//   tick    : registered one-cycle pulse, high in the cycle the LEDs
//             first show a new step
// ---------------------------------------------------------------------------
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int unsigned NUM_LEDS   = 8,
    parameter int unsigned PRESCALE_W = 21,
    parameter int unsigned PWM_W      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [NUM_LEDS-1:0] pattern,
    output logic [NUM_LEDS-1:0] led,
    output logic                tick
);

    localparam int unsigned POS_W = (NUM_LEDS > 2) ? $clog2(NUM_LEDS) : 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_LEDS - 1);

    logic                strobe;

    mode_e               active_mode_q, active_mode_d;
    logic [NUM_LEDS-1:0] step_q,        step_d;
    logic [POS_W-1:0]    pos_q,         pos_d;
    dir_e                dir_q,         dir_d;
    logic [PWM_W-1:0]    duty_q,        duty_d;
    logic [PWM_W-1:0]    pwm_q,         pwm_d;
    logic [NUM_LEDS-1:0] led_q,         led_d;
    logic                tick_q,        tick_d;

    mode_e               mode_req;

    tick_gen #(
        .WIDTH (PRESCALE_W)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .strobe (strobe)
    );

    assign mode_req = mode_e'(mode);

    // Next-state for mode latch and pattern registers.
    always_comb begin
        active_mode_d = active_mode_q;
        step_d        = step_q;
        pos_d         = pos_q;
        dir_d         = dir_q;
        duty_d        = duty_q;

        if (strobe) begin
            if (mode_req != active_mode_q) begin
                // A mode switch re-initialises pattern state instead of stepping.
                active_mode_d = mode_req;
                step_d        = '0;
                pos_d         = '0;
                dir_d         = DIR_UP;
                duty_d        = '0;
            end else begin
                case (active_mode_q)
                    MODE_BINARY: begin
                        step_d = step_q + 1'b1;
                    end
                    MODE_CHASE: begin
                        // Bounce: reverse at either end without repeating it.
                        if (dir_q == DIR_UP) begin
                            if (pos_q == LAST_POS) begin
                                dir_d = DIR_DOWN;
                                pos_d = LAST_POS - 1'b1;
                            end else begin
                                pos_d = pos_q + 1'b1;
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = DIR_UP;
                                pos_d = POS_W'(1);
                            end else begin
                                pos_d = pos_q - 1'b1;
                            end
                        end
                    end
                    MODE_BREATHE: begin
                        // Triangle ramp between 0 and full scale, no end repeats.
                        if (dir_q == DIR_UP) begin
                            if (duty_q == '1) begin
                                dir_d  = DIR_DOWN;
                                duty_d = duty_q - 1'b1;
                            end else begin
                                duty_d = duty_q + 1'b1;
                            end
                        end else begin
                            if (duty_q == '0) begin
                                dir_d  = DIR_UP;
                                duty_d = PWM_W'(1);
                            end else begin
                                duty_d = duty_q - 1'b1;
                            end
                        end
                    end
                    default: begin
                        // MODE_STATIC carries no stepping state.
                    end
                endcase
            end
        end
    end

    // PWM counter free-runs regardless of en.
    always_comb begin
        pwm_d  = pwm_q + 1'b1;
        tick_d = strobe;
    end

    // Output mux works from the next-state values so that led and tick
    // change together on the clock after the strobe edge.
    always_comb begin
        led_d = '0;
        case (active_mode_d)
            MODE_BINARY: begin
                // led[0] is the slowest channel (MSB of step).
                for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                    led_d[i] = step_d[NUM_LEDS-1-i];
                end
            end
            MODE_CHASE: begin
                led_d = NUM_LEDS'(1) << pos_d;
            end
            MODE_BREATHE: begin
                led_d = {NUM_LEDS{pwm_d < duty_d}};
            end
            default: begin
                led_d = pattern;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_mode_q <= MODE_BINARY;
            step_q        <= '0;
            pos_q         <= '0;
            dir_q         <= DIR_UP;
            duty_q        <= '0;
            pwm_q         <= '0;
            led_q         <= '0;
            tick_q        <= 1'b0;
        end else begin
            active_mode_q <= active_mode_d;
            step_q        <= step_d;
            pos_q         <= pos_d;
            dir_q         <= dir_d;
            duty_q        <= duty_d;
            pwm_q         <= pwm_d;
            led_q         <= led_d;
            tick_q        <= tick_d;
        end
    end

    assign led  = led_q;
    assign tick = tick_q;

endmodule : led_pattern_ctrl

// File: tb/tb_led_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_ctrl
// Two instances: A (8 LEDs) exercises the four modes, B (4 LEDs) the
// freeze and asynchronous reset behaviour. Both use a 2-bit prescaler and
// 2-bit PWM. A step-count model predicts led/tick for every cycle; directed
// literal checks pin the model at step boundaries.
// ---------------------------------------------------------------------------
module tb_led_pattern_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a;
    logic [1:0] mode_a;
    logic [7:0] pattern_a, led_a;
    logic       tick_a;

    logic       rst_b, en_b;
    logic [1:0] mode_b;
    logic [3:0] pattern_b, led_b;
    logic       tick_b;

    int unsigned total = 0;
    int unsigned bad   = 0;

    led_pattern_ctrl #(
        .NUM_LEDS   (8),
        .PRESCALE_W (2),
        .PWM_W      (2)
    ) dut_a (
        .clk     (clk),
        .rst     (rst_a),
        .en      (en_a),
        .mode    (mode_a),
        .pattern (pattern_a),
        .led     (led_a),
        .tick    (tick_a)
    );

    led_pattern_ctrl #(
        .NUM_LEDS   (4),
        .PRESCALE_W (2),
        .PWM_W      (2)
    ) dut_b (
        .clk     (clk),
        .rst     (rst_b),
        .en      (en_b),
        .mode    (mode_b),
        .pattern (pattern_b),
        .led     (led_b),
        .tick    (tick_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Triangle wave 0..top..0 with no repeated endpoints.
    function automatic int unsigned tri_wave(input int unsigned k, input int unsigned top);
        int unsigned r;
        r = k % (2 * top);
        return (r <= top) ? r : (2 * top - r);
    endfunction

    // Expected LED word for a given mode and number of steps since entering it.
    function automatic logic [7:0] model_led(input int unsigned amode, input int unsigned k,
                                             input int unsigned pwm, input logic [7:0] pat,
                                             input int unsigned n);
        logic [7:0]  r;
        logic [7:0]  mask;
        int unsigned s;
        mask = 8'((1 << n) - 1);
        r    = '0;
        case (amode)
            0: begin
                s = k % (1 << n);
                for (int i = 0; i < int'(n); i++) r[i] = ((s >> (int'(n) - 1 - i)) & 1) != 0;
            end
            1: r = 8'(1 << tri_wave(k, n - 1));
            2: r = (pwm < tri_wave(k, 3)) ? mask : 8'h00;
            default: r = pat & mask;
        endcase
        return r;
    endfunction

    // Model A: counts enabled clocks and steps since the last mode entry.
    int unsigned ma_ec = 0, ma_k = 0, ma_mode = 0, ma_pwm = 0;
    logic [7:0]  ma_led = '0;
    logic        ma_tick = 1'b0;

    always @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            ma_ec = 0; ma_k = 0; ma_mode = 0; ma_pwm = 0; ma_led = '0; ma_tick = 1'b0;
        end else begin
            ma_pwm  = (ma_pwm + 1) % 4;
            ma_tick = 1'b0;
            if (en_a) begin
                ma_ec++;
                if (ma_ec % 4 == 0) begin
                    ma_tick = 1'b1;
                    if (int'(mode_a) != int'(ma_mode)) begin
                        ma_mode = int'(mode_a);
                        ma_k    = 0;
                    end else begin
                        ma_k++;
                    end
                end
            end
            ma_led = model_led(ma_mode, ma_k, ma_pwm, pattern_a, 8);
        end
    end

    int unsigned mb_ec = 0, mb_k = 0, mb_mode = 0, mb_pwm = 0;
    logic [7:0]  mb_led = '0;
    logic        mb_tick = 1'b0;

    always @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            mb_ec = 0; mb_k = 0; mb_mode = 0; mb_pwm = 0; mb_led = '0; mb_tick = 1'b0;
        end else begin
            mb_pwm  = (mb_pwm + 1) % 4;
            mb_tick = 1'b0;
            if (en_b) begin
                mb_ec++;
                if (mb_ec % 4 == 0) begin
                    mb_tick = 1'b1;
                    if (int'(mode_b) != int'(mb_mode)) begin
                        mb_mode = int'(mode_b);
                        mb_k    = 0;
                    end else begin
                        mb_k++;
                    end
                end
            end
            mb_led = model_led(mb_mode, mb_k, mb_pwm, {4'b0, pattern_b}, 4);
        end
    end

    // Every-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        check("a_led",  32'(led_a),  32'(ma_led));
        check("a_tick", 32'(tick_a), 32'(ma_tick));
        check("b_led",  32'({4'b0, led_b}), 32'(mb_led));
        check("b_tick", 32'(tick_b), 32'(mb_tick));
    end

    task automatic wait_tick(input bit sel_b, input int unsigned budget, output int unsigned n);
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            seen = sel_b ? tick_b : tick_a;
        end
        if (!seen) check("tick_timeout", 32'd0, 32'd1);
    endtask

    logic [7:0] chase_seq [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                   8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic [7:0] bin_seq   [4]  = '{8'h80, 8'h40, 8'hC0, 8'h20};
    int unsigned duty_seq [7]  = '{0, 1, 2, 3, 2, 1, 0};

    initial begin
        int unsigned n;
        int unsigned on_cnt;

        rst_a = 1'b0; en_a = 1'b1; mode_a = 2'd0; pattern_a = 8'h00;
        rst_b = 1'b0; en_b = 1'b1; mode_b = 2'd1; pattern_b = 4'h0;
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        check("reset_led",  32'(led_a),  32'h0);
        check("reset_tick", 32'(tick_a), 32'h0);
        @(negedge clk);
        rst_a = 1'b0;

        // Scenario 1: binary blink, tick every 4 clocks.
        for (int i = 0; i < 4; i++) begin
            wait_tick(1'b0, 10, n);
            check("bin_period", n, 32'd4);
            check("bin_led", 32'(led_a), 32'(bin_seq[i]));
        end
        repeat (24) @(posedge clk);
        #1;

        // Scenario 2: bounce chase (mode adopted on the next strobe).
        wait_tick(1'b0, 10, n);
        mode_a = 2'd1;
        for (int i = 0; i < 16; i++) begin
            wait_tick(1'b0, 10, n);
            check("chase_led", 32'(led_a), 32'(chase_seq[i]));
            check("chase_onehot", $countones(led_a), 32'd1);
        end

        // Scenario 3: breathe, on-cycles per pwm window equal duty.
        mode_a = 2'd2;
        for (int i = 0; i < 7; i++) begin
            wait_tick(1'b0, 10, n);
            on_cnt = (led_a == 8'hFF) ? 1 : 0;
            repeat (3) begin
                @(posedge clk);
                #1;
                if (led_a == 8'hFF) on_cnt++;
            end
            check("breathe_duty", on_cnt, duty_seq[i]);
        end

        // Scenario 4: static pattern, live update.
        mode_a    = 2'd3;
        pattern_a = 8'hA5;
        wait_tick(1'b0, 10, n);
        check("static_a5", 32'(led_a), 32'hA5);
        pattern_a = 8'h3C;
        @(posedge clk);
        #1;
        check("static_3c", 32'(led_a), 32'h3C);

        // Scenario 5: 4-LED chase, freeze, then async reset mid-step.
        @(negedge clk);
        rst_b = 1'b0;
        wait_tick(1'b1, 10, n);
        check("b_first_tick", n, 32'd4);
        check("b_chase0", 32'(led_b), 32'h1);
        wait_tick(1'b1, 10, n);
        check("b_chase1", 32'(led_b), 32'h2);
        wait_tick(1'b1, 10, n);
        check("b_chase2", 32'(led_b), 32'h4);
        @(posedge clk);
        #1;
        en_b = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("b_freeze_led",  32'(led_b),  32'h4);
            check("b_freeze_tick", 32'(tick_b), 32'h0);
        end
        en_b = 1'b1;
        wait_tick(1'b1, 10, n);
        check("b_resume_n", n, 32'd3);
        check("b_chase3", 32'(led_b), 32'h8);
        @(posedge clk);
        @(negedge clk);
        rst_b  = 1'b1;
        mode_b = 2'd0;
        #1;
        check("b_async_led",  32'(led_b),  32'h0);
        check("b_async_tick", 32'(tick_b), 32'h0);
        @(negedge clk);
        rst_b = 1'b0;
        wait_tick(1'b1, 10, n);
        check("b_rst_first_tick", n, 32'd4);
        check("b_bin1", 32'(led_b), 32'h8);
        wait_tick(1'b1, 10, n);
        check("b_bin2", 32'(led_b), 32'h4);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_led_pattern_ctrl

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Parametrised N-channel LED pattern controller for the iCEBreaker board LED banks. It generalises the fixed 8-LED counter blinker:
- configurable channel count, prescale rate and PWM resolution;
- four runtime-selectable modes: binary-rate blink, bounce chase, PWM breathe and static pattern.

It sits directly between the board clock and the LED pins, with mode and pattern driven by switches or a host register.

## Interface
- NUM_LEDS, 8, number of LED channels (≥2)
- PRESCALE_W, 21, prescaler width; one step tick every 2^PRESCALE_W enabled clocks
- PWM_W, 4, PWM counter/duty width for breathe mode
- clk  input  1  board clock, all logic on rising edge
- rst  input  1  reset, asynchronous and active-high
- en  input  1  count enable; low freezes prescaler and all pattern state
- mode  input  2  requested mode: 0 BINARY, 1 CHASE, 2 BREATHE, 3 STATIC
- pattern  input  NUM_LEDS  static pattern for STATIC mode
- led  output  NUM_LEDS  registered LED drive, 1 = on
- tick  output  1  registered one-cycle pulse marking each step boundary

## Operation
- Prescaler: `presc` (PRESCALE_W bits) increments each clk while en=1 and wraps 2^W−1→0.
  - Step strobe fires when presc = all-ones and en=1.
  - `tick` is that strobe registered.
- Mode latch: `active_mode` updates only on a step strobe, and only when mode ≠ active_mode.
  - On a mode switch, pattern state is re-initialised in that same strobe instead of stepping: step=0, pos=0, dir=up, duty=0.
  - Mode changes between strobes are ignored until the next strobe.
- BINARY: `step` (NUM_LEDS bits) increments on each strobe and wraps. led[i] = step[NUM_LEDS−1−i], so led[0] is the slowest channel.
- CHASE: exactly one LED lit at index pos. On each strobe pos moves in direction dir.
  - At pos=NUM_LEDS−1, dir flips to down and pos steps to NUM_LEDS−2.
  - At pos=0 with dir down, dir flips to up and pos steps to 1.
  - No endpoint repeats.
- BREATHE: `duty` (PWM_W bits) ramps 0→2^PWM_W−1→0 as a triangle, one step per strobe, with no repeat at the ends.
  - `pwm` (PWM_W bits) free-runs every clk regardless of en.
  - All led = (pwm < duty), so duty=0 means fully off.
- STATIC: led = pattern, sampled every clk.
- en=0: presc, step, pos, dir, duty and active_mode all hold. led keeps following the frozen state (plus live pattern/pwm).

## Timing
- Reset values: led=0, tick=0, presc=0, step=0, pos=0, dir=up, duty=0, pwm=0, active_mode=BINARY.
- Pattern state updates on the strobe edge. led reflects the new state one clk later (registered output).
- tick is high in the same cycle led first shows the new step.
- Step period = 2^PRESCALE_W enabled clocks. First strobe occurs at the 2^PRESCALE_W-th enabled clk after reset release.
- Reset asserted mid-operation clears everything immediately (asynchronous). Operation restarts in BINARY mode from step 0.
- A mode change that coincides with a strobe takes effect on that strobe.

## Structure
- Shared package `led_pkg`: 2-bit mode constants MODE_BINARY, MODE_CHASE, MODE_BREATHE, MODE_STATIC and the mode typedef.
- One sub-module `tick_gen` (params WIDTH; ports clk, rst, en, strobe) holds the prescaler.
- Mode FSM, pattern registers and output mux live in the top-level module.

## Test plan
Scenarios 1–4 use PRESCALE_W=2, NUM_LEDS=8, PWM_W=2; scenario 5 changes the parameters as stated.
1. Reset release, mode=0, en=1, run 40 clks → tick every 4 clks; led sequence 00,80,40,C0,20… (led[7] toggles each step).
2. mode=1 → chase after the switch strobe: led=01,02,04,…,80,40,…,02,01,02; exactly one bit set every cycle.
3. mode=2 → duty sequence 0,1,2,3,2,1,0; over each 4-clk pwm window the count of led=FF cycles equals duty.
4. mode=3, pattern=A5 → led=A5 one clk after the switch strobe. Change pattern to 3C → led=3C on the next clk.
5. Freeze and reset, with NUM_LEDS=4 in chase mode:
   - Drop en for 10 clks → led and pos unchanged, no tick.
   - Assert rst for 1 cycle mid-step → led=0 immediately, BINARY resumes from step 0 with the first tick 4 clks after release.
